// File: rtl/msg_rom_if.sv
// Command/stream bundle between a text sink controller and msg_rom_streamer.
// The streamer takes commands, so it sits on the slave modport.
interface msg_rom_if #(
    parameter int DATA_W = 8,
    parameter int N_MSG  = 4
);
    localparam int SEL_W = (N_MSG > 1) ? $clog2(N_MSG) : 1;

    logic              i_start;
    logic [SEL_W-1:0]  i_msg_sel;
    logic              i_loop;
    logic              i_stop;
    logic              i_ready;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_busy;
    logic              o_done;

    modport master (
        output i_start, i_msg_sel, i_loop, i_stop, i_ready,
        input  o_valid, o_data, o_busy, o_done
    );

    modport slave (
        input  i_start, i_msg_sel, i_loop, i_stop, i_ready,
        output o_valid, o_data, o_busy, o_done
    );
endinterface

// File: rtl/msg_rom_streamer.sv
// Streams one terminator-ended message out of a slotted synchronous-read ROM.
// ROM contents come from the packed INIT_IMAGE parameter (word k at bits k*DATA_W +: DATA_W).
module msg_rom_streamer #(
    parameter int                          DATA_W     = 8,
    parameter int                          N_MSG      = 4,
    parameter int                          SLOT_LEN   = 32,
    parameter logic [DATA_W-1:0]           TERM       = '0,
    parameter logic [N_MSG*SLOT_LEN*DATA_W-1:0] INIT_IMAGE = '0
) (
    input  logic     i_clock,
    input  logic     i_reset,
    msg_rom_if.slave bus
);
    localparam int DEPTH = N_MSG * SLOT_LEN;
    localparam int LW    = $clog2(SLOT_LEN);
    localparam int SW    = (N_MSG > 1) ? $clog2(N_MSG) : 1;
    localparam int AW    = (N_MSG > 1) ? SW + LW : LW;
    localparam logic [LW:0] OFF_END = (LW+1)'(SLOT_LEN);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_e;

    logic [DATA_W-1:0] rom [DEPTH];
    logic [DATA_W-1:0] rom_q;
    logic [AW-1:0]     addr;
    logic [SW-1:0]     slot_q;
    logic [LW:0]       off_q;
    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic              eom;

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom[g] = INIT_IMAGE[g*DATA_W +: DATA_W];
    end

    // Offset is one bit wider than the slot index, so only its low bits address
    // the ROM; the fetch after the last word re-reads the slot start harmlessly.
    if (N_MSG > 1) begin : g_multi
        assign addr = {slot_q, off_q[LW-1:0]};
    end else begin : g_single
        assign addr = off_q[LW-1:0];
    end

    assign eom          = (rom_q == TERM) || (off_q == OFF_END);
    assign bus.o_valid  = (state_q == SEND) && !eom;
    assign bus.o_data   = bus.o_valid ? rom_q : '0;
    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;

    always_ff @(posedge i_clock) begin
        rom_q <= rom[addr];
        if (i_reset) begin
            state_q <= IDLE;
            slot_q  <= '0;
            off_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && bus.i_stop) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.i_start && !bus.i_stop) begin
                            slot_q  <= SW'(bus.i_msg_sel);
                            off_q   <= '0;
                            state_q <= FETCH;
                            busy_q  <= 1'b1;
                        end
                    end
                    FETCH: state_q <= SEND;
                    SEND: begin
                        if (eom) begin
                            if (bus.i_loop) begin
                                off_q   <= '0;
                                state_q <= FETCH;
                            end else begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end
                        end else if (bus.i_ready) begin
                            off_q   <= off_q + (LW+1)'(1);
                            state_q <= FETCH;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule
